// File: rtl/minc_pkg.sv
// Shared definitions for the minc stack CPU: ROM geometry, loader frame constants and FSM states.
package minc_pkg;

    localparam int unsigned MINC_ADDR_W    = 8;
    localparam int unsigned MINC_INSN_W    = 12;
    localparam logic [7:0]  MINC_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StCount,
        StHi,
        StLo,
        StWrite,
        StChk,
        StDone,
        StErr
    } loader_state_t;

endpackage

// File: rtl/minc_prog_loader.sv
// Program loader: turns a SYNC/COUNT/{HI,LO}*/CHK byte stream into instruction ROM writes and
// releases the CPU from reset only once a checksum-valid image has been written.
module minc_prog_loader
    import minc_pkg::*;
#(
    parameter int unsigned ADDR_W = MINC_ADDR_W,
    parameter int unsigned INSN_W = MINC_INSN_W,
    parameter logic [7:0]  SYNC   = MINC_SYNC_BYTE
) (
    input  logic              CLK,
    input  logic              nRESET,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_waddr,
    output logic [INSN_W-1:0] rom_wdata,
    output logic              cpu_nreset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned HI_W = INSN_W - 8;

    loader_state_t   state;
    logic            run;
    logic [7:0]      csum;
    logic [ADDR_W:0] words_left;
    logic            accept;
    logic            hi_bad;
    logic [7:0]      chk_sum;

    // run keeps rx_ready low while nRESET is asserted and rises on the first clock after release
    assign rx_ready = run & (state != StWrite);
    assign accept   = rx_valid & rx_ready;
    assign hi_bad   = |(rx_data >> HI_W);
    assign chk_sum  = csum + rx_data;

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state      <= StIdle;
            run        <= 1'b0;
            rom_we     <= 1'b0;
            rom_waddr  <= '0;
            rom_wdata  <= '0;
            cpu_nreset <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            csum       <= '0;
            words_left <= '0;
        end else begin
            run    <= 1'b1;
            rom_we <= 1'b0;
            case (state)
                StIdle, StDone, StErr: begin
                    if (accept && rx_data == SYNC) begin
                        state      <= StCount;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        cpu_nreset <= 1'b0;
                        busy       <= 1'b1;
                        rom_waddr  <= '0;
                        csum       <= '0;
                    end
                end
                StCount: begin
                    if (accept) begin
                        // A zero count selects the full ROM
                        words_left <= (rx_data == 8'd0) ? {1'b1, {ADDR_W{1'b0}}}
                                                        : (ADDR_W+1)'(rx_data);
                        csum       <= chk_sum;
                        state      <= StHi;
                    end
                end
                StHi: begin
                    if (accept) begin
                        if (hi_bad) begin
                            state <= StErr;
                            err   <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            rom_wdata[INSN_W-1:8] <= rx_data[HI_W-1:0];
                            csum                  <= chk_sum;
                            state                 <= StLo;
                        end
                    end
                end
                StLo: begin
                    if (accept) begin
                        rom_wdata[7:0] <= rx_data;
                        csum           <= chk_sum;
                        rom_we         <= 1'b1;
                        state          <= StWrite;
                    end
                end
                StWrite: begin
                    rom_waddr  <= rom_waddr + 1'b1;
                    words_left <= words_left - 1'b1;
                    state      <= (words_left == (ADDR_W+1)'(1)) ? StChk : StHi;
                end
                StChk: begin
                    if (accept) begin
                        busy <= 1'b0;
                        if (chk_sum == 8'd0) begin
                            state      <= StDone;
                            done       <= 1'b1;
                            cpu_nreset <= 1'b1;
                        end else begin
                            state <= StErr;
                            err   <= 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_minc_prog_loader.sv
// Scoreboard bench for minc_prog_loader: frames are built from word lists, expected ROM writes are
// queued at issue time and a monitor pops them against every rom_we strobe.
module tb_minc_prog_loader;

    logic        CLK;
    logic        nRESET;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        rom_we;
    logic [7:0]  rom_waddr;
    logic [11:0] rom_wdata;
    logic        cpu_nreset;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct {
        logic [7:0]  a;
        logic [11:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [11:0] wq[$];
    int          checks = 0;
    int          errors = 0;

    minc_prog_loader dut (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rom_we     (rom_we),
        .rom_waddr  (rom_waddr),
        .rom_wdata  (rom_wdata),
        .cpu_nreset (cpu_nreset),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sampled 1ns after each rising edge, independent of the stimulus process
    initial begin
        wr_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (nRESET) begin
                chk("rx_ready_only_low_in_write", rx_ready, !rom_we);
                if (rom_we) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: addr %0h data %0h, none expected",
                                 rom_waddr, rom_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("write_addr", rom_waddr, e.a);
                        chk("write_data", rom_wdata, e.d);
                    end
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rx_ready"}, rx_ready, 0);
        chk({tag, "_rom_we"}, rom_we, 0);
        chk({tag, "_rom_waddr"}, rom_waddr, 0);
        chk({tag, "_rom_wdata"}, rom_wdata, 0);
        chk({tag, "_cpu_nreset"}, cpu_nreset, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    // Called just after a falling edge; returns just after the falling edge following acceptance
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int waited = 0;
        if (gaps && $urandom_range(3) == 0) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(2, 1)) @(negedge CLK);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && waited < 10) begin
            @(negedge CLK);
            waited++;
        end
        if (!rx_ready) begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout: byte %0h not accepted in 10 cycles", b);
        end else begin
            @(negedge CLK);
        end
    endtask

    task automatic idle(input int cycles);
        rx_valid = 1'b0;
        repeat (cycles) @(negedge CLK);
    endtask

    // Sends a frame carrying wq[0..n-1]; bad_idx replaces that word's HI byte with bad_hi,
    // abort_after stops after that many words, delta is added to the correct checksum.
    task automatic send_frame(input int n, input int bad_idx, input logic [7:0] bad_hi,
                              input int abort_after, input logic [7:0] delta, input bit gaps);
        logic [7:0] sum;
        logic [7:0] hb;
        logic [7:0] lb;
        logic [7:0] cb;
        bit         good;
        send_byte(8'hA5, gaps);
        chk("busy_after_sync", busy, 1);
        chk("done_clear_after_sync", done, 0);
        chk("err_clear_after_sync", err, 0);
        chk("cpu_held_after_sync", cpu_nreset, 0);
        cb  = 8'(n);
        sum = cb;
        send_byte(cb, gaps);
        for (int i = 0; i < n; i++) begin
            if (i == abort_after) return;
            hb = {4'h0, wq[i][11:8]};
            lb = wq[i][7:0];
            if (i == bad_idx) begin
                send_byte(bad_hi, gaps);
                chk("bad_hi_err", err, 1);
                chk("bad_hi_done", done, 0);
                chk("bad_hi_busy", busy, 0);
                chk("bad_hi_cpu_nreset", cpu_nreset, 0);
                return;
            end
            exp_q.push_back('{a: 8'(i), d: wq[i]});
            send_byte(hb, gaps);
            send_byte(lb, gaps);
            sum = sum + hb + lb;
        end
        cb   = 8'h00 - sum + delta;
        good = (delta == 8'h00);
        send_byte(cb, gaps);
        chk("frame_done", done, good);
        chk("frame_err", err, !good);
        chk("frame_cpu_nreset", cpu_nreset, good);
        chk("frame_busy", busy, 0);
        chk("frame_writes_outstanding", exp_q.size(), 0);
    endtask

    task automatic fill_random(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back(12'($urandom_range(4095)));
    endtask

    task automatic send_junk(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(255));
            if (b == 8'hA5) b = 8'h11;
            send_byte(b, 1'b1);
        end
    endtask

    initial begin
        int n;
        int mode;
        nRESET   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge CLK);
        check_reset_vals("reset");
        nRESET = 1'b1;
        @(negedge CLK);
        chk("ready_after_release", rx_ready, 1);

        // Stray byte, then a two-word image
        send_byte(8'h11, 1'b0);
        chk("stray_byte_no_busy", busy, 0);
        wq = '{12'h005, 12'h400};
        send_frame(2, -1, 8'h00, -1, 8'h00, 1'b0);
        idle(2);

        // Same image, checksum off by one
        send_frame(2, -1, 8'h00, -1, 8'h01, 1'b0);
        idle(2);

        // Illegal HI byte in the first word, then recovery
        fill_random(4);
        send_frame(4, 0, 8'h15, -1, 8'h00, 1'b0);
        send_junk(3);
        wq = '{12'h123, 12'hFFF};
        send_frame(2, -1, 8'h00, -1, 8'h00, 1'b0);
        idle(1);

        // SYNC value as payload
        wq = '{12'h0A5, 12'h5A5, 12'hA5A};
        send_frame(3, -1, 8'h00, -1, 8'h00, 1'b0);
        chk("sync_payload_addr_end", rom_waddr, 3);

        // Full ROM, rx_valid held high throughout
        fill_random(256);
        send_frame(256, -1, 8'h00, -1, 8'h00, 1'b0);
        chk("full_rom_addr_wrap", rom_waddr, 0);
        idle(1);

        // Reset in the middle of a frame
        fill_random(8);
        send_frame(8, -1, 8'h00, 3, 8'h00, 1'b0);
        nRESET   = 1'b0;
        rx_valid = 1'b0;
        #1;
        check_reset_vals("midframe_reset");
        chk("midframe_writes_outstanding", exp_q.size(), 0);
        @(negedge CLK);
        nRESET = 1'b1;
        @(negedge CLK);
        fill_random(5);
        send_frame(5, -1, 8'h00, -1, 8'h00, 1'b0);

        // Randomized frames: good, bad checksum, or bad HI byte
        for (int f = 0; f < 30; f++) begin
            n    = $urandom_range(12, 1);
            mode = $urandom_range(2);
            fill_random(n);
            send_junk($urandom_range(2));
            if (mode == 0)
                send_frame(n, -1, 8'h00, -1, 8'h00, 1'b1);
            else if (mode == 1)
                send_frame(n, -1, 8'h00, -1, 8'($urandom_range(255, 1)), 1'b1);
            else
                send_frame(n, $urandom_range(n - 1), 8'($urandom_range(255, 16)), -1, 8'h00,
                           1'b1);
            idle($urandom_range(2));
        end

        idle(4);
        chk("final_writes_outstanding", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
